// File: rtl/ex_issue_stage_if.sv
// Decode-to-ALU issue bus: decode offer, bypass producers and ALU operand handshake.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; valid never waits on ready.
interface ex_issue_stage_if #(
  parameter int W    = 32,
  parameter int RIDX = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [RIDX-1:0] in_rs_idx;
  logic [RIDX-1:0] in_rt_idx;
  logic [RIDX-1:0] in_dst_idx;
  logic [W-1:0]    in_rs_val;
  logic [W-1:0]    in_rt_val;
  logic [W-1:0]    in_imm;
  logic [4:0]      in_shamt;
  logic [2:0]      in_alucont;
  logic            in_src_imm;
  logic            in_shift_var;
  logic            fwd1_en;
  logic [RIDX-1:0] fwd1_idx;
  logic [W-1:0]    fwd1_val;
  logic            fwd1_pending;
  logic            fwd2_en;
  logic [RIDX-1:0] fwd2_idx;
  logic [W-1:0]    fwd2_val;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [2:0]      alu_cont;
  logic [RIDX-1:0] out_dst_idx;

  modport master (
    output in_valid, in_rs_idx, in_rt_idx, in_dst_idx, in_rs_val, in_rt_val, in_imm,
           in_shamt, in_alucont, in_src_imm, in_shift_var,
           fwd1_en, fwd1_idx, fwd1_val, fwd1_pending, fwd2_en, fwd2_idx, fwd2_val, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_cont, out_dst_idx
  );

  modport slave (
    input  in_valid, in_rs_idx, in_rt_idx, in_dst_idx, in_rs_val, in_rt_val, in_imm,
           in_shamt, in_alucont, in_src_imm, in_shift_var,
           fwd1_en, fwd1_idx, fwd1_val, fwd1_pending, fwd2_en, fwd2_idx, fwd2_val, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_cont, out_dst_idx
  );
endinterface

// File: rtl/ex_issue_stage.sv
// Issue register with EX/MEM + MEM/WB bypass, load-use stall and a 2-entry skid buffer.
// Optional EX_ISSUE_PERF_EN adds saturating hazard/bubble cycle counters.
module ex_issue_stage #(
  parameter int W    = 32,
  parameter int RIDX = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  ex_issue_stage_if.slave   bus
`ifdef EX_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_hazard_cycles,
  output logic [31:0]       perf_bubble_cycles
`endif
);
  typedef struct packed {
    logic            full;
    logic [RIDX-1:0] rs_idx;
    logic [RIDX-1:0] rt_idx;
    logic [RIDX-1:0] dst;
    logic [W-1:0]    rs_val;
    logic [W-1:0]    rt_val;
    logic [W-1:0]    imm;
    logic [4:0]      shamt;
    logic [2:0]      alucont;
    logic            src_imm;
    logic            shift_var;
  } entry_t;

  entry_t o_q, s_q, o_b, s_b, in_b, o_v;
  logic   shift, rs_used, rt_used, hz, acc, ret;

  // EX/MEM wins over MEM/WB; r0 is hardwired and never forwarded.
  function automatic logic [W-1:0] byp(input logic [RIDX-1:0] idx, input logic [W-1:0] val);
    if (idx != '0 && bus.fwd1_en && bus.fwd1_idx == idx) return bus.fwd1_val;
    if (idx != '0 && bus.fwd2_en && bus.fwd2_idx == idx) return bus.fwd2_val;
    return val;
  endfunction

  function automatic entry_t byp_e(input entry_t e);
    entry_t r;
    r        = e;
    r.rs_val = byp(e.rs_idx, e.rs_val);
    r.rt_val = byp(e.rt_idx, e.rt_val);
    return r;
  endfunction

  always_comb begin
    in_b           = '0;
    in_b.full      = 1'b1;
    in_b.rs_idx    = bus.in_rs_idx;
    in_b.rt_idx    = bus.in_rt_idx;
    in_b.dst       = bus.in_dst_idx;
    in_b.rs_val    = bus.in_rs_val;
    in_b.rt_val    = bus.in_rt_val;
    in_b.imm       = bus.in_imm;
    in_b.shamt     = bus.in_shamt;
    in_b.alucont   = bus.in_alucont;
    in_b.src_imm   = bus.in_src_imm;
    in_b.shift_var = bus.in_shift_var;
    in_b           = byp_e(in_b);
    o_b            = byp_e(o_q);
    s_b            = byp_e(s_q);
    // An empty O shows its stale fields unbypassed so idle outputs stay still.
    o_v            = o_q.full ? o_b : o_q;
  end

  always_comb begin
    shift   = o_q.alucont inside {3'b100, 3'b101, 3'b110};
    rs_used = !(shift && !o_q.shift_var);
    rt_used = shift || !o_q.src_imm;
    hz      = o_q.full && bus.fwd1_en && bus.fwd1_pending &&
              ((rs_used && o_q.rs_idx != '0 && bus.fwd1_idx == o_q.rs_idx) ||
               (rt_used && o_q.rt_idx != '0 && bus.fwd1_idx == o_q.rt_idx));
  end

  assign bus.in_ready    = !s_q.full;
  assign bus.out_valid   = o_q.full && !hz;
  assign acc             = bus.in_valid && bus.in_ready;
  assign ret             = bus.out_valid && bus.out_ready;
  assign bus.alu_a       = shift ? {{(W-5){1'b0}}, (o_v.shift_var ? o_v.rs_val[4:0] : o_v.shamt)}
                                 : o_v.rs_val;
  assign bus.alu_b       = (!shift && o_v.src_imm) ? o_v.imm : o_v.rt_val;
  assign bus.alu_cont    = o_q.alucont;
  assign bus.out_dst_idx = o_q.dst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= '0;
      s_q <= '0;
    end else if (flush) begin
      o_q.full <= 1'b0;
      s_q.full <= 1'b0;
    end else if (!o_q.full || ret) begin
      if (s_q.full) begin
        o_q <= s_b;
        if (acc) s_q <= in_b;
        else     s_q.full <= 1'b0;
      end else if (acc) begin
        o_q <= in_b;
      end else begin
        o_q.full <= 1'b0;
      end
    end else begin
      // Held entries keep absorbing producers so a stall never loses a result.
      o_q <= o_b;
      if (acc) s_q <= in_b;
      else     s_q <= s_b;
    end
  end

`ifdef EX_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hazard_cycles <= '0;
      perf_bubble_cycles <= '0;
    end else begin
      if (hz && perf_hazard_cycles != 32'hFFFF_FFFF)
        perf_hazard_cycles <= perf_hazard_cycles + 32'd1;
      if (!o_q.full && !flush && perf_bubble_cycles != 32'hFFFF_FFFF)
        perf_bubble_cycles <= perf_bubble_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed scenarios plus random traffic against a queue-based model.
module tb_ex_issue_stage;
  localparam int W    = 32;
  localparam int RIDX = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ex_issue_stage_if #(.W(W), .RIDX(RIDX)) bus ();

`ifdef EX_ISSUE_PERF_EN
  logic [31:0] perf_hazard_cycles, perf_bubble_cycles;
  int unsigned m_hz_cnt, m_bub_cnt;
  ex_issue_stage #(.W(W), .RIDX(RIDX)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .perf_hazard_cycles(perf_hazard_cycles), .perf_bubble_cycles(perf_bubble_cycles));
`else
  ex_issue_stage #(.W(W), .RIDX(RIDX)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
`endif

  typedef struct {
    logic [RIDX-1:0] rs_idx, rt_idx, dst;
    logic [W-1:0]    rs_val, rt_val, imm;
    logic [4:0]      shamt;
    logic [2:0]      op;
    logic            src_imm, shift_var;
  } instr_t;

  instr_t       mq[$];     // instructions held by the stage, oldest first
  logic [W-1:0] exp_q[$];  // destinations in expected retire order
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fv(input logic [RIDX-1:0] idx, input logic [W-1:0] v);
    if (idx == 0) return v;
    if (bus.fwd1_en && bus.fwd1_idx == idx) return bus.fwd1_val;
    if (bus.fwd2_en && bus.fwd2_idx == idx) return bus.fwd2_val;
    return v;
  endfunction

  function automatic bit is_shift(input logic [2:0] op);
    return op == 3'd4 || op == 3'd5 || op == 3'd6;
  endfunction

  function automatic bit m_hz();
    instr_t h;
    bit rs_used, rt_used;
    if (mq.size() == 0) return 1'b0;
    h = mq[0];
    rs_used = !(is_shift(h.op) && !h.shift_var);
    rt_used = is_shift(h.op) || !h.src_imm;
    return bus.fwd1_en && bus.fwd1_pending &&
           ((rs_used && h.rs_idx != 0 && bus.fwd1_idx == h.rs_idx) ||
            (rt_used && h.rt_idx != 0 && bus.fwd1_idx == h.rt_idx));
  endfunction

  // Compare the current cycle against the model, advance the model, then cross one clock.
  task automatic step();
    bit hz, ev, er;
    instr_t h, e;
    logic [W-1:0] a, b, rs, rt;
    #1;
    hz = m_hz();
    ev = (mq.size() > 0) && !hz;
    er = mq.size() < 2;
    check("out_valid", W'(bus.out_valid), W'(ev));
    check("in_ready", W'(bus.in_ready), W'(er));
    if (ev) begin
      h  = mq[0];
      rs = fv(h.rs_idx, h.rs_val);
      rt = fv(h.rt_idx, h.rt_val);
      if (is_shift(h.op)) begin
        a = h.shift_var ? W'(rs[4:0]) : W'(h.shamt);
        b = rt;
      end else begin
        a = rs;
        b = h.src_imm ? h.imm : rt;
      end
      check("alu_a", bus.alu_a, a);
      check("alu_b", bus.alu_b, b);
      check("alu_cont", W'(bus.alu_cont), W'(h.op));
    end
`ifdef EX_ISSUE_PERF_EN
    if (hz) m_hz_cnt++;
    if (mq.size() == 0 && !flush) m_bub_cnt++;
`endif
    if (flush) begin
      mq.delete();
      exp_q.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) begin
        mq[i].rs_val = fv(mq[i].rs_idx, mq[i].rs_val);
        mq[i].rt_val = fv(mq[i].rt_idx, mq[i].rt_val);
      end
      if (ev && bus.out_ready) begin
        check("retire_order", W'(bus.out_dst_idx), exp_q.pop_front());
        void'(mq.pop_front());
      end
      if (bus.in_valid && er) begin
        e.rs_idx = bus.in_rs_idx;   e.rt_idx = bus.in_rt_idx;   e.dst = bus.in_dst_idx;
        e.rs_val = fv(bus.in_rs_idx, bus.in_rs_val);
        e.rt_val = fv(bus.in_rt_idx, bus.in_rt_val);
        e.imm = bus.in_imm;  e.shamt = bus.in_shamt;  e.op = bus.in_alucont;
        e.src_imm = bus.in_src_imm;  e.shift_var = bus.in_shift_var;
        mq.push_back(e);
        exp_q.push_back(W'(bus.in_dst_idx));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [RIDX-1:0] rsi, input logic [W-1:0] rsv,
                        input logic [RIDX-1:0] rti, input logic [W-1:0] rtv,
                        input logic [W-1:0] imm, input logic [4:0] shamt, input logic [2:0] op,
                        input logic simm, input logic svar, input logic [RIDX-1:0] dst);
    bus.in_valid = 1'b1;
    bus.in_rs_idx = rsi;  bus.in_rs_val = rsv;  bus.in_rt_idx = rti;  bus.in_rt_val = rtv;
    bus.in_imm = imm;  bus.in_shamt = shamt;  bus.in_alucont = op;
    bus.in_src_imm = simm;  bus.in_shift_var = svar;  bus.in_dst_idx = dst;
  endtask

  task automatic fwd_off();
    bus.fwd1_en = 1'b0; bus.fwd1_idx = '0; bus.fwd1_val = '0; bus.fwd1_pending = 1'b0;
    bus.fwd2_en = 1'b0; bus.fwd2_idx = '0; bus.fwd2_val = '0;
  endtask

  task automatic peek(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    #1;
    check({tag, "_valid"}, W'(bus.out_valid), 1);
    check({tag, "_a"}, bus.alu_a, a);
    check({tag, "_b"}, bus.alu_b, b);
  endtask

  initial begin
    set_in('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    fwd_off();
`ifdef EX_ISSUE_PERF_EN
    m_hz_cnt = 0; m_bub_cnt = 0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", W'(bus.out_valid), 0);
    check("rst_in_ready", W'(bus.in_ready), 1);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_cont", W'(bus.alu_cont), 0);
    check("rst_dst", W'(bus.out_dst_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain add, then an immediate-shift and a variable shift.
    set_in(5, 7, 6, 3, 0, 0, 3'b010, 1'b0, 1'b0, 1);
    step(); bus.in_valid = 1'b0;
    peek("add", 7, 3);
    check("add_cont", W'(bus.alu_cont), 2);
    step();
    set_in(0, 0, 2, 1, 0, 4, 3'b100, 1'b0, 1'b0, 2);
    step(); bus.in_valid = 1'b0;
    peek("sll", 4, 1);
    step();
    set_in(3, 32'hFFFF_FF23, 2, 1, 0, 0, 3'b110, 1'b0, 1'b1, 3);
    step(); bus.in_valid = 1'b0;
    peek("srav", 3, 1);
    step();

    // Forward priority, and r0 never forwarded.
    bus.fwd1_en = 1'b1; bus.fwd1_idx = 8; bus.fwd1_val = 32'hAA;
    bus.fwd2_en = 1'b1; bus.fwd2_idx = 8; bus.fwd2_val = 32'hBB;
    set_in(8, 32'h11, 0, 0, 32'h40, 0, 3'b010, 1'b1, 1'b0, 4);
    step(); bus.in_valid = 1'b0;
    peek("fwd_prio", 32'hAA, 32'h40);
    step(); fwd_off();
    bus.fwd1_en = 1'b1; bus.fwd1_idx = 0; bus.fwd1_val = 32'hAA;
    set_in(0, 32'h123, 0, 0, 32'h8, 0, 3'b010, 1'b1, 1'b0, 5);
    step(); bus.in_valid = 1'b0;
    peek("fwd_r0", 32'h123, 32'h8);
    step(); fwd_off();

    // Backpressure fills both entries; release drains in order.
    bus.out_ready = 1'b0;
    set_in(1, 32'h100, 2, 32'h200, 0, 0, 3'b000, 1'b0, 1'b0, 6);
    step();
    set_in(1, 32'h300, 2, 32'h400, 0, 0, 3'b001, 1'b0, 1'b0, 7);
    step(); bus.in_valid = 1'b0;
    #1 check("bp_in_ready", W'(bus.in_ready), 0);
    check("bp_head_dst", W'(bus.out_dst_idx), 6);
    bus.out_ready = 1'b1;
    step();
    check("bp_second_dst", W'(bus.out_dst_idx), 7);
    step(); step();

    // Load-use stall on rt, then late data, then producer gone.
    set_in(0, 0, 9, 32'h1, 0, 0, 3'b010, 1'b0, 1'b0, 8);
    step(); bus.in_valid = 1'b0;
    bus.fwd1_en = 1'b1; bus.fwd1_idx = 9; bus.fwd1_val = 32'hDEAD; bus.fwd1_pending = 1'b1;
    repeat (2) begin
      #1 check("lu_stall", W'(bus.out_valid), 0);
      step();
    end
    bus.fwd1_pending = 1'b0; bus.fwd1_val = 32'h55; bus.out_ready = 1'b0;
    peek("lu_fwd", 0, 32'h55);
    step(); fwd_off();
    peek("lu_hold", 0, 32'h55);
    bus.out_ready = 1'b1;
    step(); step();

    // Flush with both entries full and a new offer.
    bus.out_ready = 1'b0;
    set_in(1, 1, 2, 2, 0, 0, 3'b010, 1'b0, 1'b0, 10);
    step();
    set_in(1, 3, 2, 4, 0, 0, 3'b011, 1'b0, 1'b0, 11);
    step();
    set_in(1, 5, 2, 6, 0, 0, 3'b111, 1'b0, 1'b0, 12);
    flush = 1'b1;
    step(); flush = 1'b0; bus.in_valid = 1'b0;
    #1 check("flush_valid", W'(bus.out_valid), 0);
    check("flush_ready", W'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset in the middle of a held instruction.
    bus.out_ready = 1'b0;
    set_in(4, 9, 5, 9, 0, 0, 3'b010, 1'b0, 1'b0, 13);
    step(); bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("arst_valid", W'(bus.out_valid), 0);
    check("arst_ready", W'(bus.in_ready), 1);
    check("arst_alu_a", bus.alu_a, 0);
    mq.delete(); exp_q.delete();
`ifdef EX_ISSUE_PERF_EN
    m_hz_cnt = 0; m_bub_cnt = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with a small register pool to provoke matches.
    for (int i = 0; i < 800; i++) begin
      set_in(RIDX'($urandom_range(0, 3)), $urandom, RIDX'($urandom_range(0, 3)), $urandom,
             $urandom, 5'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
             RIDX'($urandom));
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.out_ready    = ($urandom_range(0, 3) != 0);
      bus.fwd1_en      = 1'($urandom);
      bus.fwd1_idx     = RIDX'($urandom_range(0, 3));
      bus.fwd1_val     = $urandom;
      bus.fwd1_pending = ($urandom_range(0, 5) == 0);
      bus.fwd2_en      = 1'($urandom);
      bus.fwd2_idx     = RIDX'($urandom_range(0, 3));
      bus.fwd2_val     = $urandom;
      flush            = ($urandom_range(0, 24) == 0);
      step();
    end
    flush = 1'b0;

`ifdef EX_ISSUE_PERF_EN
    #1 check("perf_hazard", perf_hazard_cycles, m_hz_cnt);
    check("perf_bubble", perf_bubble_cycles, m_bub_cnt);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- Issue register between decode and the execute-stage ALU.
- Captures one decoded instruction per handshake and resolves operand bypassing from the EX/MEM and MEM/WB stages.
- Selects the ALU operand layout: a = shift amount for shifts; b = immediate or rt.
- Drives the ALU's a, b and alucont through a 2-entry skid buffer so that in_ready never combinationally depends on out_ready.

Parameters:
- W, 32, datapath width.
- RIDX, 5, register index width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- flush  in  1  synchronous kill of all held entries (branch mispredict / exception).
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage can accept; equals !skid_full.
- in_rs_idx, in_rt_idx, in_dst_idx  in  RIDX  source and destination register indices.
- in_rs_val, in_rt_val  in  W  register-file read data.
- in_imm  in  W  immediate, already sign/zero-extended.
- in_shamt  in  5  instruction shamt field.
- in_alucont  in  3  ALU op: 000 and, 001 or, 010 add, 011 sub, 100 sll, 101 srl, 110 sra, 111 slt.
- in_src_imm  in  1  b takes the immediate instead of rt.
- in_shift_var  in  1  shift amount comes from rs[4:0] instead of shamt.
- fwd1_en, fwd1_idx, fwd1_val, fwd1_pending  in  1/RIDX/W/1  EX/MEM producer; pending means load data is not yet available.
- fwd2_en, fwd2_idx, fwd2_val  in  1/RIDX/W  MEM/WB producer.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream accepts.
- alu_a, alu_b  out  W  ALU operands.
- alu_cont  out  3  ALU opcode.
- out_dst_idx  out  RIDX  destination passthrough.

Behaviour:
- State: out entry (O) and skid entry (S).
  - Each entry holds full, rs/rt idx+val, imm, shamt, alucont, src_imm, shift_var and dst.
- Reset: O.full = 0 and S.full = 0, so out_valid = 0 and in_ready = 1. All outputs are 0, including alu_a, alu_b, alu_cont and out_dst_idx.
- Reset is asynchronous. Asserting it mid-operation discards all entries with no partial-state survival.
- Accept condition: acc = in_valid & in_ready.
- Retire condition: ret = out_valid & out_ready.
- Refill routing, evaluated in priority order:
  - If O empty or ret: O <= S if S.full, otherwise O <= input if acc, otherwise O.full <= 0.
  - If S supplied O and acc, S <= input; otherwise S.full <= 0.
  - If O stays full and not ret, an acc goes into S.
- Order is strictly FIFO. Throughput is 1 per cycle with out_ready held high; latency from in to out_valid is 1 cycle.
- Bypass:
  - Operand value = fwd1_val if fwd1_en & fwd1_idx == idx & idx != 0.
  - Otherwise fwd2_val if fwd2 matches likewise.
  - Otherwise the stored value.
  - Index 0 is never forwarded.
- Bypass is applied both combinationally to the O outputs and written back every cycle into the stored rs/rt values of O and S, so a producer retiring during a stall is not lost.
- Incoming instructions are bypassed before storage.
- Load-use hazard: hz = O.full & fwd1_en & fwd1_pending & fwd1_idx matches a used nonzero source of O.
  - rs is used unless (shift & !shift_var); rt is used for shifts or !src_imm.
  - out_valid = O.full & !hz. O is held; nothing retires.
- Operand mapping, with shift = alucont in {100, 101, 110}:
  - alu_a = shift ? {27'b0, shift_var ? rs[4:0] : shamt} : rs.
  - alu_b = shift ? rt : (src_imm ? imm : rt).
- flush: next cycle O.full = S.full = 0 and the same-cycle acc is dropped. flush wins over all simultaneous events. in_ready during flush is still !S.full.
- out_valid low: alu_a, alu_b and alu_cont hold their last values; no requirement beyond stability.

Optional Feature:
- Macro: EX_ISSUE_PERF_EN.
- When defined: adds outputs perf_hazard_cycles and perf_bubble_cycles, each 32-bit, reset to 0.
  - perf_hazard_cycles increments each cycle hz = 1.
  - perf_bubble_cycles increments each cycle O.full = 0 and flush = 0.
  - Both saturate at 0xFFFFFFFF.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset then add: rs = 5 (val 7), rt = 6 (val 3), alucont = 010, out_ready = 1 → next cycle out_valid = 1, alu_a = 7, alu_b = 3, alu_cont = 010.
- Shift: sll, shamt = 4, shift_var = 0, rt_val = 1 → alu_a = 4, alu_b = 1. Then srav with rs_val = 0xFFFFFF23, shift_var = 1 → alu_a = 3.
- Forward priority: rs_idx = 8, fwd1 idx 8 val 0xAA, fwd2 idx 8 val 0xBB → alu_a = 0xAA. With rs_idx = 0 and a fwd1 idx 0 match → alu_a = in_rs_val.
- Backpressure: out_ready = 0 and two accepts → in_ready = 0 after the second. Raise out_ready → both entries emerge in order on consecutive cycles; no loss or duplication.
- Load-use: fwd1 pending on rt = 9 for 2 cycles, then pending = 0 with val 0x55 → out_valid = 0 for 2 cycles, then alu_b = 0x55. Dropping fwd1 the cycle after still gives alu_b = 0x55 from the stored update.
- Flush with both entries full and in_valid = 1 → next cycle out_valid = 0, in_ready = 1, and no stale instruction ever appears.
